// File: rtl/aq_djpeg_seq_pkg.sv
// Shared types and constants for the JPEG decoder frame sequencer.
package aq_djpeg_seq_pkg;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StReset = 3'd1,
    StRun   = 3'd2,
    StDrain = 3'd3,
    StDone  = 3'd4,
    StErr   = 3'd5
  } seq_state_e;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_PROG    = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;
  localparam logic [1:0] ERR_ABORT   = 2'b11;

  // True when pos is the last index of a dimension; a zero size never matches,
  // which keeps the 16-bit wrap of size-1 from producing a false hit at 0xFFFF.
  function automatic logic is_last(input logic [15:0] pos, input logic [15:0] size);
    return (size != 16'd0) && (pos == size - 16'd1);
  endfunction

endpackage

// File: rtl/aq_djpeg_seq_wdog.sv
// Stall watchdog: counts enabled cycles and flags expiry when the stall length
// reaches the limit. A limit of zero disables expiry.
module aq_djpeg_seq_wdog #(
  parameter int unsigned TIMEOUT_W = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 clear,
  input  logic [TIMEOUT_W-1:0] limit,
  output logic                 expire
);

  localparam logic [TIMEOUT_W-1:0] One = {{(TIMEOUT_W-1){1'b0}}, 1'b1};

  logic [TIMEOUT_W-1:0] cnt_q;

  // Stall counter; clear wins over enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (enable) begin
      cnt_q <= cnt_q + One;
    end
  end

  // Expire on the cycle that completes a stall of exactly 'limit' cycles, so the
  // owner leaves on the following edge.
  always_comb begin
    expire = enable && !clear && (limit != '0) && (cnt_q == limit - One);
  end

endmodule

// File: rtl/aq_djpeg_frame_seq.sv
// Frame sequencer for the JPEG decoder: owns decoder reset, gates the input
// stream to one frame per start, counts pixels, emits framing markers and
// reports completion/error status.
module aq_djpeg_frame_seq
  import aq_djpeg_seq_pkg::*;
#(
  parameter int unsigned RST_CYCLES = 16,
  parameter int unsigned TIMEOUT_W  = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [TIMEOUT_W-1:0] timeout_cycles,
  input  logic                 dec_idle,
  input  logic                 dec_progressive,
  input  logic                 dec_out_en,
  input  logic [15:0]          dec_width,
  input  logic [15:0]          dec_height,
  input  logic [15:0]          dec_pixel_x,
  input  logic [15:0]          dec_pixel_y,
  output logic                 dec_run,
  output logic                 in_gate,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic [1:0]           err_code,
  output logic                 sof,
  output logic                 eol,
  output logic                 eof,
  output logic [31:0]          pix_count,
  output logic [15:0]          frame_count
);

  localparam int unsigned RstCntW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RstCntW-1:0] RstLast = RstCntW'(RST_CYCLES - 1);
  localparam logic [RstCntW-1:0] RstOne  = RstCntW'(1);

  seq_state_e state_q, state_d;
  logic [1:0] err_set;

  logic [RstCntW-1:0] rst_cnt_q;
  logic               dec_run_q, in_gate_q, busy_q, done_q, error_q;
  logic [1:0]         err_code_q;
  logic [31:0]        pix_count_q;
  logic [15:0]        frame_count_q;

  logic in_run, wd_active, wd_expire, start_ok, final_pix;

  assign in_run    = (state_q == StRun);
  assign wd_active = (state_q == StRun) || (state_q == StDrain);
  assign start_ok  = (state_q == StIdle) && start;

  aq_djpeg_seq_wdog #(
    .TIMEOUT_W (TIMEOUT_W)
  ) u_wdog (
    .clk    (clk),
    .rst    (rst),
    .enable (wd_active && !dec_out_en),
    .clear  (!wd_active || dec_out_en),
    .limit  (timeout_cycles),
    .expire (wd_expire)
  );

  // Framing markers, combinational from the live pixel strobe.
  always_comb begin
    sof       = dec_out_en && in_run && (pix_count_q == 32'd0);
    eol       = dec_out_en && in_run && is_last(dec_pixel_x, dec_width);
    eof       = eol && is_last(dec_pixel_y, dec_height);
    final_pix = eof;
  end

  // Next-state logic; err_set carries the code latched on entry to StErr.
  // DONE and ERR already report completion, so abort there is not re-reported.
  always_comb begin
    state_d = state_q;
    err_set = ERR_NONE;
    case (state_q)
      StIdle: begin
        if (start) state_d = StReset;
      end
      StReset: begin
        if (abort) begin
          state_d = StErr;
          err_set = ERR_ABORT;
        end else if (rst_cnt_q == RstLast) begin
          state_d = StRun;
        end
      end
      StRun: begin
        if (abort) begin
          state_d = StErr;
          err_set = ERR_ABORT;
        end else if (dec_progressive) begin
          state_d = StErr;
          err_set = ERR_PROG;
        end else if (wd_expire) begin
          state_d = StErr;
          err_set = ERR_TIMEOUT;
        end else if (final_pix) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (abort) begin
          state_d = StErr;
          err_set = ERR_ABORT;
        end else if (wd_expire) begin
          state_d = StErr;
          err_set = ERR_TIMEOUT;
        end else if (dec_idle) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      StErr:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State register and decoder reset hold counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      rst_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      rst_cnt_q <= (state_q == StReset) ? rst_cnt_q + RstOne : '0;
    end
  end

  // Control outputs registered from the next state so they align with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dec_run_q <= 1'b0;
      in_gate_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      dec_run_q <= (state_d == StRun) || (state_d == StDrain);
      in_gate_q <= (state_d == StRun);
      busy_q    <= (state_d != StIdle);
      done_q    <= (state_d == StDone) || (state_d == StErr);
    end
  end

  // Sticky error status: cleared by an accepted start, set on entry to ERR.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      error_q    <= 1'b0;
      err_code_q <= ERR_NONE;
    end else if (start_ok) begin
      error_q    <= 1'b0;
      err_code_q <= ERR_NONE;
    end else if (state_d == StErr && state_q != StErr) begin
      error_q    <= 1'b1;
      err_code_q <= err_set;
    end
  end

  // Pixel counter, saturating; frame counter bumps on successful completion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_count_q   <= '0;
      frame_count_q <= '0;
    end else begin
      if (start_ok) begin
        pix_count_q <= '0;
      end else if (in_run && dec_out_en && (pix_count_q != '1)) begin
        pix_count_q <= pix_count_q + 32'd1;
      end
      if (state_q == StDrain && state_d == StDone) begin
        frame_count_q <= frame_count_q + 16'd1;
      end
    end
  end

  assign dec_run     = dec_run_q;
  assign in_gate     = in_gate_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign error       = error_q;
  assign err_code    = err_code_q;
  assign pix_count   = pix_count_q;
  assign frame_count = frame_count_q;

endmodule
